utopia1_atm_rx: RTL and testbench
=================================

// Module: utopia1_atm_rx
// PURPOSE
// - UTOPIA-1 cell receiver: the downstream peer of utopia1_atm_tx. Accepts the 53-byte
//   soc/en/data byte stream, back-pressures with clav and rebuilds the parallel NNI fields.
// - Presents each complete cell to the switch core with a rxreq/rxack handshake.
//   The byte order is the one utopia1_atm_tx produces.
// PARAMETERS
// - PAYLOAD_BYTES  48   payload bytes per cell; header is fixed at 5 bytes
// - TIMEOUT        256  idle cycles (en=0) allowed mid-cell before abort; 0 = no timeout
// - CNT_W          16   width of the good-cell counter
// PORTS
// - clk          in   1      clock, all logic on rising edge
// - rst          in   1      asynchronous, active-high reset
// - soc          in   1      start of cell; high with the first header byte
// - data         in   8      cell byte, valid when en=1
// - en           in   1      byte valid strobe
// - clav         out  1      cell space available to the transmitter
// - rxreq        out  1      complete cell held on nni_* outputs
// - rxack        in   1      core has taken the cell
// - nni_VPI      out  12     {byte0, byte1[7:4]}
// - nni_VCI      out  16     {byte1[3:0], byte2, byte3[7:4]}
// - nni_CLP      out  1      byte3[3]
// - nni_PT       out  3      byte3[2:0]
// - nni_HEC      out  8      byte4
// - nni_Payload  out  384    payload byte k at [8k+7:8k]; k=0 is the first payload byte
// - cell_cnt     out  CNT_W  good cells delivered; saturates at all-ones
// - abort_err    out  1      1-cycle pulse: cell aborted (early soc or timeout)
// - ovf_err      out  1      1-cycle pulse: en=1 while in HOLD, byte discarded
// - hec_err      out  1      1-cycle pulse: HEC mismatch (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: all outputs 0, FSM=IDLE, byte counter 0. clav rises 1 clk after rst falls.
// - FSM states: IDLE, HDR, PAY, DROP, HOLD. A byte is accepted on any edge with en=1.
// - IDLE: en&soc -> store byte0, cnt=1, go to HDR. en without soc is ignored.
// - HDR/PAY: each en stores data[cnt], then cnt+1. en=0 stalls with all state held.
//   - HDR -> PAY after byte 4.
//   - PAY -> HOLD after the last payload byte (cnt = 5+PAYLOAD_BYTES-1).
//   - en&soc in HDR/PAY: abort_err pulse; the byte is taken as byte0 of a new cell (cnt=1, HDR).
//   - Timeout: TIMEOUT consecutive en=0 cycles in HDR/PAY -> abort_err pulse, go to IDLE.
// - HOLD: rxreq=1 from the cycle after the last byte is accepted; nni_* stable; clav=0.
//   - rxack=1 -> rxreq=0, increment cell_cnt, clav=1 and IDLE, all on the next cycle.
//   - en=1 in HOLD -> ovf_err pulse; byte is dropped, state unchanged.
// - rxack outside HOLD is ignored. nni_* hold the last cell until the next one completes.
// - Fields are updated byte-by-byte into a shadow register. nni_* load from the shadow
//   on the HOLD entry edge, so they never show a partial cell.
// - clav=1 in IDLE/HDR/PAY/DROP, 0 in HOLD; registered from the next state.
// - Reset mid-cell drops the partial cell silently; no error pulse.
// CONFIGURATION
// - Macro HEC_CHECK_EN defined:
//   - CRC-8 (x^8+x^2+x+1, init 0x00) computed over bytes 0-3, then XOR 0x55.
//   - Compared with byte4 on acceptance. Mismatch -> hec_err pulse next cycle.
//   - On mismatch go to DROP, which consumes the PAYLOAD_BYTES payload bytes
//     (same soc/timeout rules as PAY), then IDLE. No rxreq and no cell_cnt increment.
// - Macro undefined: no CRC logic, DROP unreachable, hec_err tied 0, nni_HEC = byte4 as received.
// TESTING
// - Stream VPI=0xABC VCI=0x1234 CLP=1 PT=5 payload k=k:
//   - Required: rxreq=1 the cycle after byte 52.
//   - Required: nni_VPI=0xABC, nni_VCI=0x1234, nni_CLP=1, nni_PT=5, nni_Payload[15:8]=0x01.
//   - Required: rxack -> cell_cnt=1, clav=1.
// - Same cell with en=0 for 3 cycles after byte 20 (TIMEOUT=256) -> cell still delivered intact.
// - soc reasserted at byte 30, then a full cell follows:
//   - Required: one abort_err pulse; second cell delivered; cell_cnt=1.
// - Hold rxack=0 and send 2 extra bytes during HOLD:
//   - Required: 2 ovf_err pulses; nni_* unchanged; clav=0 throughout.
// - HEC_CHECK_EN, header 00 00 00 00 with byte4=0x55 -> accepted.
//   - Same header with byte4=0x54 -> hec_err pulse, no rxreq, clav stays 1.
// - TIMEOUT=8, stop after byte 10 -> abort_err at the 8th idle cycle; next soc starts cleanly.

Source files
------------

// File: rtl/utopia1_atm_rx.sv
// -----------------------------------------------------------------------------
// utopia1_atm_rx
// UTOPIA-1 cell receiver. It takes the 53-byte soc/en/data stream produced by
// utopia1_atm_tx and back-pressures it with clav. Each cell is reassembled into
// the parallel NNI fields and offered to the switch core with rxreq/rxack.
//
// Optional feature: define HEC_CHECK_EN to check the header HEC.
//   The check is CRC-8 (x^8+x^2+x+1, init 0) over bytes 0-3, then XOR 0x55.
//   A cell that fails the check gets a hec_err pulse and its payload is dropped.
//   With the macro undefined, nni_HEC is byte4 exactly as received.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   soc, data, en    cell byte stream (soc marks byte 0, en qualifies data)
//   clav             space for a new cell (low only while a cell waits in HOLD)
//   rxreq, rxack     cell-ready handshake towards the switch core
//   nni_*            header fields and payload of the last complete cell
//   cell_cnt         good cells handed over, saturating
//   abort_err        pulse: partial cell abandoned (early soc or timeout)
//   ovf_err          pulse: byte arrived while a cell was waiting in HOLD
//   hec_err          pulse: header HEC mismatch (only with HEC_CHECK_EN)
// -----------------------------------------------------------------------------
module utopia1_atm_rx #(
   parameter int PAYLOAD_BYTES = 48,
   parameter int TIMEOUT       = 256,
   parameter int CNT_W         = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       soc,
   input  logic [7:0]                 data,
   input  logic                       en,
   output logic                       clav,
   output logic                       rxreq,
   input  logic                       rxack,
   output logic [11:0]                nni_VPI,
   output logic [15:0]                nni_VCI,
   output logic                       nni_CLP,
   output logic [2:0]                 nni_PT,
   output logic [7:0]                 nni_HEC,
   output logic [8*PAYLOAD_BYTES-1:0] nni_Payload,
   output logic [CNT_W-1:0]           cell_cnt,
   output logic                       abort_err,
   output logic                       ovf_err,
   output logic                       hec_err
);

   localparam int CELL_BYTES = 5 + PAYLOAD_BYTES;
   localparam int BCNT_W     = $clog2(CELL_BYTES);
   localparam int IDLE_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [BCNT_W-1:0] LAST_IDX   = BCNT_W'(CELL_BYTES - 1);
   localparam logic [BCNT_W-1:0] HEC_IDX    = BCNT_W'(4);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_DROP, S_HOLD} state_t;

   state_t                    state_q, state_d;
   logic [BCNT_W-1:0]         cnt_q, cnt_d;
   logic [IDLE_W-1:0]         idle_q, idle_d;
   logic                      abort_d, ovf_d, hec_d, load_nni, cnt_inc;
   logic                      wr_en;
   logic [BCNT_W-1:0]         wr_idx;
   logic                      hec_bad;
   logic [7:0]                shadow_q [CELL_BYTES];
   logic [8*PAYLOAD_BYTES-1:0] pay_full;

   // NOTE: the shadow is plain storage with no reset; its content is only
   // published once every byte has been rewritten by a complete cell.
   always_ff @(posedge clk) begin
      if (wr_en) shadow_q[wr_idx] <= data;
   end

`ifdef HEC_CHECK_EN
   logic [7:0] crc_q;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
      logic [7:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? 8'h07 : 8'h00);
      return c;
   endfunction

   // Running CRC over header bytes 0-3; byte 0 always restarts it from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               crc_q <= '0;
      else if (wr_en && wr_idx == '0)        crc_q <= crc8_step(8'h00, data);
      else if (wr_en && wr_idx < HEC_IDX)    crc_q <= crc8_step(crc_q, data);
   end

   assign hec_bad = (data != (crc_q ^ 8'h55));
`else
   assign hec_bad = 1'b0;
`endif

   // The last payload byte is still on the data bus at the HOLD entry edge,
   // so it is merged here rather than read back from the shadow.
   always_comb begin
      pay_full = '0;
      for (int k = 0; k < PAYLOAD_BYTES; k++) pay_full[8*k +: 8] = shadow_q[5+k];
      pay_full[8*(PAYLOAD_BYTES-1) +: 8] = data;
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idle_d   = '0;
      abort_d  = 1'b0;
      ovf_d    = 1'b0;
      hec_d    = 1'b0;
      load_nni = 1'b0;
      cnt_inc  = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (en && soc) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               cnt_d   = BCNT_W'(1);
               state_d = S_HDR;
            end
         end

         S_HDR, S_PAY, S_DROP: begin
            if (en && soc) begin
               // Early soc: abandon the partial cell and restart on this byte.
               abort_d = 1'b1;
               wr_en   = 1'b1;
               wr_idx  = '0;
               cnt_d   = BCNT_W'(1);
               state_d = S_HDR;
            end else if (en) begin
               wr_en = (state_q != S_DROP);
               cnt_d = cnt_q + 1'b1;
               if (state_q == S_HDR) begin
                  if (cnt_q == HEC_IDX) begin
                     if (hec_bad) begin
                        hec_d   = 1'b1;
                        state_d = S_DROP;
                     end else begin
                        state_d = S_PAY;
                     end
                  end
               end else if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
                  if (state_q == S_PAY) begin
                     state_d  = S_HOLD;
                     load_nni = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else if (TIMEOUT != 0 && idle_q == IDLE_LIMIT) begin
               abort_d = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end

         S_HOLD: begin
            ovf_d = en;
            if (rxack) begin
               cnt_inc = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign rxreq = (state_q == S_HOLD);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idle_q      <= '0;
         clav        <= 1'b0;
         abort_err   <= 1'b0;
         ovf_err     <= 1'b0;
         hec_err     <= 1'b0;
         cell_cnt    <= '0;
         nni_VPI     <= '0;
         nni_VCI     <= '0;
         nni_CLP     <= 1'b0;
         nni_PT      <= '0;
         nni_HEC     <= '0;
         nni_Payload <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idle_q    <= idle_d;
         clav      <= (state_d != S_HOLD);
         abort_err <= abort_d;
         ovf_err   <= ovf_d;
         hec_err   <= hec_d;
         if (cnt_inc && cell_cnt != '1) cell_cnt <= cell_cnt + 1'b1;
         if (load_nni) begin
            nni_VPI     <= {shadow_q[0], shadow_q[1][7:4]};
            nni_VCI     <= {shadow_q[1][3:0], shadow_q[2], shadow_q[3][7:4]};
            nni_CLP     <= shadow_q[3][3];
            nni_PT      <= shadow_q[3][2:0];
            nni_HEC     <= shadow_q[4];
            nni_Payload <= pay_full;
         end
      end
   end

endmodule

// File: tb/tb_utopia1_atm_rx.sv
// -----------------------------------------------------------------------------
// tb_utopia1_atm_rx
// Directed bench for utopia1_atm_rx. Two instances share the input stream:
// dut with the default TIMEOUT and dut8 with TIMEOUT=8. Inputs change on the
// falling edge and outputs are sampled on the following falling edge. The HEC
// section follows the HEC_CHECK_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_utopia1_atm_rx;

   localparam int PB   = 48;
   localparam int CELL = 5 + PB;

   logic clk = 1'b0;
   logic rst, soc, en, rxack;
   logic [7:0] data;

   logic          clav, rxreq, abort_err, ovf_err, hec_err;
   logic [11:0]   nni_VPI;
   logic [15:0]   nni_VCI, cell_cnt;
   logic          nni_CLP;
   logic [2:0]    nni_PT;
   logic [7:0]    nni_HEC;
   logic [8*PB-1:0] nni_Payload;

   logic          clav8, rxreq8, abort8, ovf8, hec8;
   logic [11:0]   vpi8;
   logic [15:0]   vci8, cnt8;
   logic          clp8;
   logic [2:0]    pt8;
   logic [7:0]    hec_f8;
   logic [8*PB-1:0] pay8;

   utopia1_atm_rx dut (
      .clk(clk), .rst(rst), .soc(soc), .data(data), .en(en),
      .clav(clav), .rxreq(rxreq), .rxack(rxack),
      .nni_VPI(nni_VPI), .nni_VCI(nni_VCI), .nni_CLP(nni_CLP), .nni_PT(nni_PT),
      .nni_HEC(nni_HEC), .nni_Payload(nni_Payload), .cell_cnt(cell_cnt),
      .abort_err(abort_err), .ovf_err(ovf_err), .hec_err(hec_err)
   );

   utopia1_atm_rx #(.TIMEOUT(8)) dut8 (
      .clk(clk), .rst(rst), .soc(soc), .data(data), .en(en),
      .clav(clav8), .rxreq(rxreq8), .rxack(rxack),
      .nni_VPI(vpi8), .nni_VCI(vci8), .nni_CLP(clp8), .nni_PT(pt8),
      .nni_HEC(hec_f8), .nni_Payload(pay8), .cell_cnt(cnt8),
      .abort_err(abort8), .ovf_err(ovf8), .hec_err(hec8)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0]    cell_b [CELL];
   logic [11:0]   exp_vpi;
   logic [15:0]   exp_vci;
   logic          exp_clp;
   logic [2:0]    exp_pt;
   logic [7:0]    exp_hec;
   logic [8*PB-1:0] exp_pay;

   typedef struct {
      logic        soc;
      logic        en;
      logic [7:0]  data;
      logic        ack;
      logic        clav;
      logic        rxreq;
      logic        ovf;
      logic        abort;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input logic [8*PB-1:0] act, input logic [8*PB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // HEC by polynomial long division of header*x^8 by 0x107, then XOR 0x55.
   function automatic logic [7:0] hec_of(input logic [31:0] h);
      logic [39:0] r;
      r = {h, 8'h00};
      for (int i = 39; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      return r[7:0] ^ 8'h55;
   endfunction

   task automatic build_cell(input logic [11:0] vpi, input logic [15:0] vci, input logic clp,
                             input logic [2:0] pt, input logic [7:0] seed, input logic [7:0] step);
      logic [7:0] b;
      exp_vpi = vpi; exp_vci = vci; exp_clp = clp; exp_pt = pt;
      cell_b[0] = vpi[11:4];
      cell_b[1] = {vpi[3:0], vci[15:12]};
      cell_b[2] = vci[11:4];
      cell_b[3] = {vci[3:0], clp, pt};
      exp_hec   = hec_of({cell_b[0], cell_b[1], cell_b[2], cell_b[3]});
      cell_b[4] = exp_hec;
      b = seed;
      for (int k = 0; k < PB; k++) begin
         cell_b[5+k]        = b;
         exp_pay[8*k +: 8]  = b;
         b                  = b + step;
      end
   endtask

   task automatic drive(input logic s, input logic e, input logic [7:0] d, input logic a);
      soc = s; en = e; data = d; rxack = a;
      @(negedge clk);
   endtask

   task automatic send_range(input int first, input int last);
      for (int i = first; i <= last; i++) drive(i == 0, 1'b1, cell_b[i], 1'b0);
      soc = 1'b0; en = 1'b0;
   endtask

   task automatic do_reset();
      soc = 1'b0; en = 1'b0; data = 8'h00; rxack = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_fields(input string tag);
      check({tag, " VPI"}, nni_VPI, exp_vpi);
      check({tag, " VCI"}, nni_VCI, exp_vci);
      check({tag, " CLP"}, nni_CLP, exp_clp);
      check({tag, " PT"},  nni_PT,  exp_pt);
      check({tag, " HEC"}, nni_HEC, exp_hec);
      check({tag, " payload"}, nni_Payload, exp_pay);
   endtask

   initial begin
      // Overflow / handshake sequence applied while cell B waits in HOLD (cell A already taken).
      //          soc   en    data   ack    clav  rxreq ovf   abort cnt
      tbl[0] = '{1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
      tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
      tbl[2] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
      tbl[4] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};

      // Reset state
      rst = 1'b1; soc = 1'b0; en = 1'b0; data = 8'h00; rxack = 1'b0;
      repeat (2) @(negedge clk);
      check("reset clav", clav, 1'b0);
      check("reset rxreq", rxreq, 1'b0);
      check("reset cell_cnt", cell_cnt, 16'd0);
      check("reset abort", abort_err, 1'b0);
      check("reset ovf", ovf_err, 1'b0);
      check("reset hec", hec_err, 1'b0);
      check("reset VPI", nni_VPI, 12'h000);
      check("reset payload", nni_Payload, '0);
      rst = 1'b0;
      check("clav before first edge", clav, 1'b0);
      @(negedge clk);
      check("clav after reset release", clav, 1'b1);

      // Cell A: straight through
      build_cell(12'hABC, 16'h1234, 1'b1, 3'd5, 8'h00, 8'h01);
      send_range(0, 51);
      check("A rxreq before last byte", rxreq, 1'b0);
      check("A clav before last byte", clav, 1'b1);
      send_range(52, 52);
      check("A rxreq", rxreq, 1'b1);
      check("A clav in hold", clav, 1'b0);
      check("A payload byte1", nni_Payload[15:8], 8'h01);
      check_fields("A");
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("A rxreq after ack", rxreq, 1'b0);
      check("A cell_cnt", cell_cnt, 16'd1);
      check("A clav after ack", clav, 1'b1);

      // Cell B: 3 idle cycles after byte 20
      build_cell(12'h123, 16'hBEEF, 1'b0, 3'd2, 8'hFF, 8'hFF);
      send_range(0, 20);
      repeat (3) drive(1'b0, 1'b0, 8'h5A, 1'b0);
      check("B stall abort", abort_err, 1'b0);
      check("B stall rxreq", rxreq, 1'b0);
      send_range(21, 52);
      check("B rxreq", rxreq, 1'b1);
      check_fields("B");

      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].soc, tbl[i].en, tbl[i].data, tbl[i].ack);
         check($sformatf("tbl%0d clav", i),  clav,      tbl[i].clav);
         check($sformatf("tbl%0d rxreq", i), rxreq,     tbl[i].rxreq);
         check($sformatf("tbl%0d ovf", i),   ovf_err,   tbl[i].ovf);
         check($sformatf("tbl%0d abort", i), abort_err, tbl[i].abort);
         check($sformatf("tbl%0d cnt", i),   cell_cnt,  tbl[i].cnt);
      end
      check_fields("B after hold");

      // Early soc at cell position 30, then a full cell D
      do_reset();
      build_cell(12'h0F0, 16'h0F0F, 1'b0, 3'd1, 8'h40, 8'h03);
      send_range(0, 29);
      check("C partial abort", abort_err, 1'b0);
      build_cell(12'h5A5, 16'hC3C3, 1'b1, 3'd6, 8'h80, 8'h07);
      send_range(0, 0);
      check("early soc abort", abort_err, 1'b1);
      send_range(1, 1);
      check("early soc abort pulse ends", abort_err, 1'b0);
      send_range(2, 52);
      check("D rxreq", rxreq, 1'b1);
      check_fields("D");
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("D cell_cnt", cell_cnt, 16'd1);

      // Timeout on dut8 after byte 10
      do_reset();
      build_cell(12'h321, 16'h4567, 1'b0, 3'd3, 8'h10, 8'h05);
      send_range(0, 10);
      repeat (7) drive(1'b0, 1'b0, 8'h00, 1'b0);
      check("T8 abort before 8th idle", abort8, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      check("T8 abort at 8th idle", abort8, 1'b1);
      check("T256 no abort yet", abort_err, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      check("T8 abort pulse ends", abort8, 1'b0);
      check("T8 clav after abort", clav8, 1'b1);
      send_range(0, 0);
      check("T8 clean restart", abort8, 1'b0);
      check("T256 early soc abort", abort_err, 1'b1);
      send_range(1, 52);
      check("T8 rxreq", rxreq8, 1'b1);
      check("T8 VPI", vpi8, exp_vpi);
      check("T8 VCI", vci8, exp_vci);
      check("T8 CLP", clp8, exp_clp);
      check("T8 PT", pt8, exp_pt);
      check("T8 HEC", hec_f8, exp_hec);
      check("T8 payload", pay8, exp_pay);
      check("T8 ovf", ovf8, 1'b0);
      check("T8 hec_err", hec8, 1'b0);
      check("T256 rxreq", rxreq, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("T8 cell_cnt", cnt8, 16'd1);

      // Header HEC
`ifdef HEC_CHECK_EN
      build_cell(12'h000, 16'h0000, 1'b0, 3'd0, 8'h00, 8'h01);
      cell_b[4] = 8'h55; exp_hec = 8'h55;
      send_range(0, 4);
      check("good HEC no hec_err", hec_err, 1'b0);
      send_range(5, 52);
      check("good HEC rxreq", rxreq, 1'b1);
      check_fields("good HEC");
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("good HEC cell_cnt", cell_cnt, 16'd2);
      cell_b[4] = 8'h54;
      send_range(0, 4);
      check("bad HEC hec_err", hec_err, 1'b1);
      check("bad HEC clav", clav, 1'b1);
      send_range(5, 52);
      check("bad HEC no rxreq", rxreq, 1'b0);
      check("bad HEC clav after drop", clav, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      check("bad HEC still no rxreq", rxreq, 1'b0);
      check("bad HEC cell_cnt", cell_cnt, 16'd2);
`else
      build_cell(12'h000, 16'h0000, 1'b0, 3'd0, 8'h00, 8'h01);
      cell_b[4] = 8'h54; exp_hec = 8'h54;
      send_range(0, 4);
      check("unchecked HEC no hec_err", hec_err, 1'b0);
      send_range(5, 52);
      check("unchecked HEC rxreq", rxreq, 1'b1);
      check_fields("unchecked HEC");
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("unchecked HEC cell_cnt", cell_cnt, 16'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
